// File: rtl/parcel_sequencer.sv
// Splits a 64-bit instruction word into opcode + variable-length tail parcels.
// Tail length per opcode comes from an external combinational lookup.
module parcel_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_data,
    output logic        fetch_ready,
    input  logic        flush,
    output logic [3:0]  slot_nib,
    input  logic [2:0]  slot_len,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [3:0]  op,
    output logic [27:0] imm,
    output logic [2:0]  op_len,
    output logic        op_err,
    output logic        word_done
);

    typedef enum logic {StEmpty, StIssue} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [63:0] word_q, word_d;

    logic        issuing;
    logic        accept;
    logic [3:0]  cur_nib;
    logic [63:0] shifted;
    logic [27:0] tail7;
    logic [4:0]  next_pc;
    logic [4:0]  tail_end;

    always_comb begin
        issuing  = (state_q == StIssue);
        accept   = issuing & op_ready;
        // Slot k occupies bits [63-4k -: 4], i.e. low bit at 4*(15-k).
        cur_nib  = word_q[{~pc_q, 2'b00} +: 4];
        // After shifting slot pc to the top, slots pc+1..pc+7 sit in [59:32].
        shifted  = word_q << {pc_q, 2'b00};
        tail7    = 28'(shifted >> 32);
        next_pc  = {1'b0, pc_q} + 5'd1 + {2'b00, slot_len};
        tail_end = {1'b0, pc_q} + {2'b00, slot_len};
    end

    always_comb begin
        fetch_ready = ~issuing & ~flush;
        op_valid    = issuing;
        slot_nib    = issuing ? cur_nib : 4'h0;
        op          = issuing ? cur_nib : 4'h0;
        op_len      = issuing ? slot_len : 3'd0;
        imm         = issuing ? (tail7 >> {3'd7 - slot_len, 2'b00}) : 28'h0;
        op_err      = issuing & (tail_end > 5'd15);
        // An accept coinciding with flush consumes the op but never ends the word.
        word_done   = accept & ~flush & next_pc[4];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        if (flush) begin
            state_d = StEmpty;
            pc_d    = 4'h0;
        end else if (!issuing) begin
            if (fetch_valid) begin
                word_d  = fetch_data;
                pc_d    = 4'h0;
                state_d = StIssue;
            end
        end else if (accept) begin
            if (next_pc[4]) begin
                state_d = StEmpty;
                pc_d    = 4'h0;
            end else begin
                pc_d = next_pc[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            pc_q    <= 4'h0;
            word_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
        end
    end

endmodule
